// File: rtl/multi_port_xor_ram.sv
// Multi-port RAM built from one bank per port. The logical word at an address
// is the XOR of every bank at that address, so each port writes only its own
// bank and all ports can write in the same cycle without arbitration.
// A clear sequencer sweeps every bank to zero after reset.
module multi_port_xor_ram #(
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int WIDTH      = 1,
  parameter int PORTS      = 2,
  parameter int MODE       = 0,
  parameter int READ_REG   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS-1:0]            wr,
  input  logic [PORTS*ADDR_WIDTH-1:0] addr,
  input  logic [PORTS*WIDTH-1:0]      din,
  output logic [PORTS*WIDTH-1:0]      q,
  output logic                        busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;

  logic [PORTS-1:0]        in_range;
  logic [PORTS-1:0]        wr_eff;
  logic [PORTS*WIDTH-1:0]  wdata;
  logic [PORTS*WIDTH-1:0]  word;
  // Bank b read at port r's address lives at slice (b*PORTS + r).
  logic [PORTS*PORTS*WIDTH-1:0] bank_rd;

  // Addresses beyond DEPTH (non-power-of-two depth) neither write nor read.
  for (genvar gi = 0; gi < PORTS; gi++) begin : g_range
    assign in_range[gi] = {1'b0, addr[gi*ADDR_WIDTH +: ADDR_WIDTH]} < DEPTH_EXT;
  end

  // One distributed-RAM bank per port, read at every port address.
  for (genvar gi = 0; gi < PORTS; gi++) begin : g_bank
    logic [WIDTH-1:0] mem [DEPTH];

    for (genvar gr = 0; gr < PORTS; gr++) begin : g_rd
      assign bank_rd[(gi*PORTS + gr)*WIDTH +: WIDTH] =
        in_range[gr] ? mem[addr[gr*ADDR_WIDTH +: ADDR_WIDTH]] : '0;
    end

    // Bank write: the clear sweep owns the bank while clearing, else port gi.
    always_ff @(posedge clk) begin
      if (state_q == CLEAR) begin
        mem[clr_addr_q] <= '0;
      end else if (wr_eff[gi]) begin
        mem[addr[gi*ADDR_WIDTH +: ADDR_WIDTH]] <= wdata[gi*WIDTH +: WIDTH];
      end
    end
  end

  // Logical word seen by each port: XOR of all banks at that port's address.
  always_comb begin
    word = '0;
    for (int r = 0; r < PORTS; r++) begin
      for (int b = 0; b < PORTS; b++) begin
        word[r*WIDTH +: WIDTH] = word[r*WIDTH +: WIDTH] ^
                                 bank_rd[(b*PORTS + r)*WIDTH +: WIDTH];
      end
    end
  end

  // Per-port bank write data and effective enable (overwrite mode lets the
  // lowest-index port win an address collision).
  always_comb begin
    wdata  = '0;
    wr_eff = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (MODE == 0) begin
        wdata[p*WIDTH +: WIDTH] = bank_rd[(p*PORTS + p)*WIDTH +: WIDTH] ^
                                  din[p*WIDTH +: WIDTH];
      end else begin
        // word ^ own bank = XOR of the other banks at this address
        wdata[p*WIDTH +: WIDTH] = din[p*WIDTH +: WIDTH] ^ word[p*WIDTH +: WIDTH] ^
                                  bank_rd[(p*PORTS + p)*WIDTH +: WIDTH];
      end
      wr_eff[p] = wr[p] && in_range[p] && (state_q == IDLE);
      if (MODE != 0) begin
        for (int o = 0; o < p; o++) begin
          if (wr[o] && in_range[o] &&
              (addr[o*ADDR_WIDTH +: ADDR_WIDTH] == addr[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
            wr_eff[p] = 1'b0;
          end
        end
      end
    end
  end

  // Clear sequencer next state: sweep 0..DEPTH-1 once, then idle.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == CLEAR) begin
      if (clr_addr_q == LAST_ADDR) begin
        state_d    = IDLE;
        clr_addr_d = '0;
      end else begin
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Sequencer registers; reset (re)starts the sweep at address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  assign busy = (state_q == CLEAR);

  if (READ_REG != 0) begin : g_rreg
    logic [PORTS*WIDTH-1:0] rd_q, rd_d;
    assign rd_d = word;
    // Registered read captures the pre-write word on each edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_q <= '0;
      end else begin
        rd_q <= rd_d;
      end
    end
    assign q = rd_q;
  end else begin : g_rcomb
    assign q = word;
  end

endmodule

// File: tb/tb_multi_port_xor_ram.sv
// Bench for multi_port_xor_ram: three configurations share one clock.
//   u_a: DEPTH 16, 4 ports x 8 bits, overwrite, combinational read
//   u_b: default parameters (512 x 1, 2 ports, toggle)
//   u_c: DEPTH 12, 4 ports x 8 bits, toggle, registered read
module tb_multi_port_xor_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_a, busy_a;
  logic [3:0]  wr_a;
  logic [15:0] addr_a;
  logic [31:0] din_a, q_a;

  logic        rst_b, busy_b;
  logic [1:0]  wr_b, din_b, q_b;
  logic [17:0] addr_b;

  logic        rst_c, busy_c;
  logic [3:0]  wr_c;
  logic [15:0] addr_c;
  logic [31:0] din_c, q_c;

  multi_port_xor_ram #(.DEPTH(16), .ADDR_WIDTH(4), .WIDTH(8), .PORTS(4),
                       .MODE(1), .READ_REG(0)) u_a (
    .clk(clk), .rst(rst_a), .wr(wr_a), .addr(addr_a), .din(din_a),
    .q(q_a), .busy(busy_a));

  multi_port_xor_ram u_b (
    .clk(clk), .rst(rst_b), .wr(wr_b), .addr(addr_b), .din(din_b),
    .q(q_b), .busy(busy_b));

  multi_port_xor_ram #(.DEPTH(12), .ADDR_WIDTH(4), .WIDTH(8), .PORTS(4),
                       .MODE(0), .READ_REG(1)) u_c (
    .clk(clk), .rst(rst_c), .wr(wr_c), .addr(addr_c), .din(din_c),
    .q(q_c), .busy(busy_c));

  typedef struct {
    string      name;
    int         inst;
    int         port;
    logic [7:0] exp;
    int         due;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [3:0]  wr;
    logic [15:0] addr;
    logic [31:0] din;
    logic [3:0]  rd;
    logic [7:0]  exp;
  } vec_a_t;
  vec_a_t vecs[10];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endtask

  function automatic logic [7:0] get_q(input int inst, input int port);
    logic [7:0] r;
    r = '0;
    case (inst)
      0:       r = q_a[port*8 +: 8];
      1:       r = {7'b0, q_b[port]};
      default: r = q_c[port*8 +: 8];
    endcase
    return r;
  endfunction

  task automatic expect_q(input string name, input int inst, input int port,
                          input logic [7:0] exp, input int lat);
    sb_t e;
    e.name = name;
    e.inst = inst;
    e.port = port;
    e.exp  = exp;
    e.due  = cyc + lat;
    sb_q.push_back(e);
  endtask

  // Scoreboard: compare every expectation that falls due on this cycle.
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due == cyc) begin
        check(sb_q[i].name, {8'h0, get_q(sb_q[i].inst, sb_q[i].port)}, {8'h0, sb_q[i].exp});
        sb_q.delete(i);
      end
    end
  end

  // Called just after a rising edge: write cycle, then read rd on all ports.
  task automatic apply_a(input int idx);
    wr_a   = vecs[idx].wr;
    addr_a = vecs[idx].addr;
    din_a  = vecs[idx].din;
    @(posedge clk); #1;
    wr_a   = '0;
    din_a  = '0;
    addr_a = {4{vecs[idx].rd}};
    for (int p = 0; p < 4; p++)
      expect_q($sformatf("a_vec%0d_p%0d", idx, p), 0, p, vecs[idx].exp, 0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_rst_a();
    wr_a  = '0;
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
  endtask

  // Counts edges from reset release until busy drops; optionally hammers
  // address 0 with writes the whole time (they must all be ignored).
  task automatic measure_busy_a(input bit storm, output int n);
    n = 0;
    while (n < 100) begin
      if (storm) begin
        wr_a   = 4'hF;
        addr_a = '0;
        din_a  = 32'hFFFF_FFFF;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!busy_a) break;
    end
    wr_a  = '0;
    din_a = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int na, nb, nc, n;
    bit ok;

    vecs[0] = '{4'b1111, {4'd4, 4'd3, 4'd2, 4'd1}, 32'h44332211, 4'd1, 8'h11};
    vecs[1] = '{4'b0000, 16'h0, 32'h0, 4'd2, 8'h22};
    vecs[2] = '{4'b0000, 16'h0, 32'h0, 4'd3, 8'h33};
    vecs[3] = '{4'b0000, 16'h0, 32'h0, 4'd4, 8'h44};
    vecs[4] = '{4'b0101, {4'd0, 4'd7, 4'd0, 4'd7}, 32'h005500AA, 4'd7, 8'hAA};
    vecs[5] = '{4'b0010, {4'd0, 4'd0, 4'd1, 4'd0}, 32'h00005A00, 4'd1, 8'h5A};
    vecs[6] = '{4'b1100, {4'd3, 4'd3, 4'd0, 4'd0}, 32'h99770000, 4'd3, 8'h77};
    vecs[7] = '{4'b1000, {4'd2, 4'd0, 4'd0, 4'd0}, 32'h00000000, 4'd2, 8'h00};
    vecs[8] = '{4'b0011, {4'd0, 4'd0, 4'd11, 4'd10}, 32'h0000F00F, 4'd10, 8'h0F};
    vecs[9] = '{4'b0000, 16'h0, 32'h0, 4'd11, 8'hF0};

    rst_a = 1'b1; wr_a = '0; addr_a = '0; din_a = '0;
    rst_b = 1'b1; wr_b = '0; addr_b = '0; din_b = '0;
    rst_c = 1'b1; wr_c = '0; addr_c = '0; din_c = '0;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_busy_a", {15'h0, busy_a}, 16'h1);
    check("rst_busy_b", {15'h0, busy_b}, 16'h1);
    check("rst_busy_c", {15'h0, busy_c}, 16'h1);
    check("rst_q_c_zero", q_c[15:0], 16'h0);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // Busy lasts exactly DEPTH cycles after reset release
    na = 0; nb = 0; nc = 0;
    for (int k = 1; k <= 600; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (!busy_a && na == 0) na = k;
      if (!busy_b && nb == 0) nb = k;
      if (!busy_c && nc == 0) nc = k;
      if (na != 0 && nb != 0 && nc != 0) break;
    end
    check("init_busy_len_a", 16'(na), 16'd16);
    check("init_busy_len_b", 16'(nb), 16'd512);
    check("init_busy_len_c", 16'(nc), 16'd12);
    @(posedge clk); #1;

    // Toggle mode, 1-bit: two ports toggle address 5 on consecutive cycles
    wr_b = 2'b01; addr_b = {9'd5, 9'd5}; din_b = 2'b01;
    expect_q("b_before_p0", 1, 0, 8'h0, 0);
    @(posedge clk); #1;
    wr_b = 2'b10; din_b = 2'b10;
    expect_q("b_first_p0", 1, 0, 8'h1, 0);
    expect_q("b_first_p1", 1, 1, 8'h1, 0);
    @(posedge clk); #1;
    wr_b = 2'b00; din_b = 2'b00;
    expect_q("b_second_p0", 1, 0, 8'h0, 0);
    expect_q("b_second_p1", 1, 1, 8'h0, 0);
    @(posedge clk); #1;

    // Overwrite mode vector table
    for (int i = 0; i < 10; i++) apply_a(i);

    // Toggle mode collision on a registered-read instance
    wr_c = 4'b0101; addr_c = {4{4'd7}}; din_c = 32'h005500AA;
    expect_q("c_coll_old_p1", 2, 1, 8'h00, 1);
    @(posedge clk); #1;
    wr_c = '0; din_c = '0;
    for (int p = 0; p < 4; p++) expect_q($sformatf("c_coll_p%0d", p), 2, p, 8'hFF, 1);
    @(posedge clk); #1;

    // Registered read-before-write at address 9
    wr_c = 4'b0001; addr_c = {4{4'd9}}; din_c = 32'h0000003C;
    expect_q("c_rbw_old_p1", 2, 1, 8'h00, 1);
    @(posedge clk); #1;
    wr_c = '0; din_c = '0;
    expect_q("c_rbw_new_p1", 2, 1, 8'h3C, 1);
    @(posedge clk); #1;
    wr_c = 4'b1000; din_c = 32'h0F000000;
    expect_q("c_tog_old_p0", 2, 0, 8'h3C, 1);
    @(posedge clk); #1;
    wr_c = '0; din_c = '0;
    expect_q("c_tog_new_p2", 2, 2, 8'h33, 1);
    @(posedge clk); #1;

    // Out-of-range address: write ignored, read returns 0
    wr_c = 4'b0001; addr_c = {4'd13, 4'd13, 4'd13, 4'd13}; din_c = 32'h000000FF;
    expect_q("c_oor_pre_p1", 2, 1, 8'h00, 1);
    @(posedge clk); #1;
    wr_c = '0; din_c = '0; addr_c = {4'd15, 4'd1, 4'd13, 4'd13};
    expect_q("c_oor_13_p0", 2, 0, 8'h00, 1);
    expect_q("c_oor_13_p1", 2, 1, 8'h00, 1);
    expect_q("c_oor_1_p2", 2, 2, 8'h00, 1);
    expect_q("c_oor_15_p3", 2, 3, 8'h00, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Fill DEPTH 16 with nonzero data and read it back
    for (int i = 0; i < 16; i++) begin
      wr_a = 4'b0001;
      addr_a = {12'h0, 4'(i)};
      din_a = {24'h0, 8'(i + 1)};
      @(posedge clk); #1;
    end
    wr_a = '0; din_a = '0;
    for (int g = 0; g < 4; g++) begin
      for (int p = 0; p < 4; p++) begin
        addr_a[p*4 +: 4] = 4'(4*g + p);
        expect_q($sformatf("a_fill_%0d", 4*g + p), 0, p, 8'(4*g + p + 1), 0);
      end
      @(posedge clk); #1;
    end

    // Reset pulse: 16 busy cycles, writes ignored, everything reads 0
    pulse_rst_a();
    measure_busy_a(1'b1, n);
    check("a_clear_busy_len", 16'(n), 16'd16);
    @(posedge clk); #1;
    for (int g = 0; g < 4; g++) begin
      for (int p = 0; p < 4; p++) begin
        addr_a[p*4 +: 4] = 4'(4*g + p);
        expect_q($sformatf("a_cleared_%0d", 4*g + p), 0, p, 8'h00, 0);
      end
      @(posedge clk); #1;
    end

    // Reset re-pulsed at clr_addr 8 restarts the full sweep
    pulse_rst_a();
    ok = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (!busy_a) ok = 1'b0;
    end
    check("a_busy_before_repulse", {15'h0, ok}, 16'h1);
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    measure_busy_a(1'b0, n);
    check("a_repulse_busy_len", 16'(n), 16'd16);

    // First cycle after busy drops accepts port writes
    wr_a = 4'b0001; addr_a = {12'h0, 4'd3}; din_a = 32'h0000005C;
    @(posedge clk); #1;
    wr_a = '0; din_a = '0; addr_a = {4{4'd3}};
    for (int p = 0; p < 4; p++) expect_q($sformatf("a_post_busy_p%0d", p), 0, p, 8'h5C, 0);
    @(posedge clk); #1;

    // Reset zeroes the registered read output
    addr_c = {4{4'd9}};
    @(posedge clk);
    @(negedge clk);
    check("c_q_before_rst", {8'h0, q_c[15:8]}, 16'h33);
    rst_c = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("c_q_after_rst", q_c[15:0], 16'h0);
    check("c_busy_after_rst", {15'h0, busy_c}, 16'h1);
    rst_c = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("sb_drained", 16'(sb_q.size()), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_port_xor_ram.md
MULTI_PORT_XOR_RAM -- requirements
Module: multi_port_xor_ram

Interface
REQ-001: Parameter DEPTH, default 512, number of words.
REQ-002: Parameter ADDR_WIDTH, default log2(DEPTH-1) from common.vh, address width.
REQ-003: Parameter WIDTH, default 1, data bits per word.
REQ-004: Parameter PORTS, default 2, number of read/write ports; legal range 2..8.
REQ-005: Parameter MODE, default 0; 0 = toggle (word ^= din), 1 = overwrite (word = din).
REQ-006: Parameter READ_REG, default 0; 0 = combinational read, 1 = one-cycle registered read.
REQ-007: clk  input  1  single clock; all state changes on its rising edge.
REQ-008: rst  input  1  reset, synchronous, active-high.
REQ-009: wr  input  PORTS  per-port write enable; bit p belongs to port p.
REQ-010: addr  input  PORTS*ADDR_WIDTH  per-port address; slice p = addr[p*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011: din  input  PORTS*WIDTH  per-port write data; slice p = din[p*WIDTH +: WIDTH].
REQ-012: q  output  PORTS*WIDTH  per-port read data; slice p = word at addr slice p.
REQ-013: busy  output  1  high while the clear sequencer owns the memory.

Function
REQ-014: Storage SHALL be PORTS banks of DEPTH x WIDTH distributed RAM; bank p written only by port p or the clear sequencer.
REQ-015: Logical word at address a SHALL be the XOR of all banks at a; q slice p SHALL be that XOR at addr slice p.
REQ-016: Each bank SHALL provide one read per port plus one read at every port's write address (PORTS+1 reads per bank minimum).
REQ-017: MODE 0, wr[p]=1: bank p at addr_p SHALL be written with bank_p[addr_p] ^ din_p, so the logical word toggles by din_p.
REQ-018: MODE 1, wr[p]=1: bank p at addr_p SHALL be written with din_p ^ (XOR of all other banks at addr_p), so the logical word becomes din_p.
REQ-019: MODE 0 same-address writes from several ports in one cycle SHALL accumulate: new word = old ^ XOR of all colliding din.
REQ-020: MODE 1 same-address writes: lowest-index writing port SHALL win; higher-index colliding writes SHALL be suppressed.
REQ-021: READ_REG=0: q SHALL follow addr combinationally; a write becomes visible on q in the cycle after its clock edge.
REQ-022: READ_REG=1: q SHALL register the word at addr on each edge, read-before-write (value prior to same-edge writes); latency 1 cycle.
REQ-023: Writes to addresses >= DEPTH (non-power-of-two DEPTH) SHALL be ignored; reads there SHALL return 0.
REQ-024: Clear sequencer states: IDLE, CLEAR; 0..DEPTH-1 counter clr_addr, ADDR_WIDTH bits.
REQ-025: In CLEAR, every bank at clr_addr SHALL be written 0 each cycle, clr_addr incremented; after writing DEPTH-1 state SHALL go to IDLE.
REQ-026: busy SHALL be 1 exactly while state = CLEAR.
REQ-027: While busy=1, all wr SHALL be ignored; q SHALL still reflect current contents.
REQ-028: Contents SHALL also be initialised to 0 at time zero (simulation initial block).

Reset
REQ-029: rst=1 at an edge SHALL set state=CLEAR, clr_addr=0, busy=1 in the next cycle, and zero registered q (READ_REG=1).
REQ-030: rst held high SHALL keep clr_addr at 0 (address 0 rewritten each cycle); counting starts on the first edge with rst=0.
REQ-031: rst asserted mid-CLEAR SHALL restart the sweep at address 0.
REQ-032: After rst deasserts, busy SHALL remain 1 for exactly DEPTH cycles, then drop to 0; port writes accepted from that cycle.

Verification
REQ-033: PORTS=2, MODE=0, WIDTH=1: port0 toggles addr 5 din=1, next cycle port1 toggles addr 5 din=1 -> q at 5 reads 1 then 0.
REQ-034: PORTS=4, MODE=1, WIDTH=8: ports 0..3 write 0x11,0x22,0x33,0x44 to addrs 1..4 same cycle -> all four read back exactly on every port.
REQ-035: MODE=1 collision: ports 0 and 2 write 0xAA and 0x55 to addr 7 same cycle -> addr 7 reads 0xAA; MODE=0 same stimulus, old 0 -> reads 0xFF.
REQ-036: READ_REG=1: write 0x3C to addr 9 while port1 reads addr 9 same edge -> q1=old value next cycle, 0x3C the cycle after.
REQ-037: Fill DEPTH=16 with nonzero data, pulse rst 1 cycle -> busy=1 for 16 cycles, writes during busy ignored, all addresses read 0 after.
REQ-038: rst re-pulsed at clr_addr=8 of DEPTH=16 sweep -> busy stays high 16 more cycles from rst deassert, no early IDLE.
